// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundles the scan controller's control inputs and display/status outputs.
// The master (stimulus) drives en/load/bcd_in; the slave (controller) drives the rest.
interface seven_seg_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [6:0]  svnsg;
    logic [3:0]  dig;
    logic        upd_pend;
    logic        frame_done;
    logic        err;

    modport master (
        output en, load, bcd_in,
        input  svnsg, dig, upd_pend, frame_done, err
    );

    modport slave (
        input  en, load, bcd_in,
        output svnsg, dig, upd_pend, frame_done, err
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-aligned value updates; all outputs registered.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module seven_seg_scan_ctrl #(
    parameter int PRESCALE  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] SHOW_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] GAP_LAST  = 16'(BLANK_CYC - 1);

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] applied, applied_nxt;
    logic [15:0] pending, pending_nxt;
    logic        upd, upd_nxt;
    logic        boundary;
    logic        apply_now;
    logic        blank;
    logic [3:0]  cur_digit;
    logic [6:0]  seg_q, seg_nxt;
    logic [3:0]  dig_q, dig_nxt;
    logic        fd_q;
    logic        err_q, err_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic has_bad_digit(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
               (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and everything above it are zero.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
        logic b;
        case (i)
            2'd3:    b = (v[15:12] == 4'd0);
            2'd2:    b = (v[15:8]  == 8'd0);
            2'd1:    b = (v[15:4]  == 12'd0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction
`endif

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        applied_nxt = applied;
        pending_nxt = pending;
        upd_nxt     = upd;
        boundary    = 1'b0;

        case (state)
            OFF: begin
                if (bus.en) begin
                    state_nxt = SHOW;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = 16'd0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = SHOW;
                    idx_nxt   = idx + 2'd1;
                    cnt_nxt   = 16'd0;
                    boundary  = (idx == 2'd3);
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = OFF;
                idx_nxt   = 2'd0;
                cnt_nxt   = 16'd0;
            end
        endcase

        if (!bus.en) begin
            state_nxt = OFF;
            idx_nxt   = 2'd0;
            cnt_nxt   = 16'd0;
            boundary  = 1'b0;
        end

        // A load landing exactly on a boundary goes straight to the display.
        apply_now = boundary || (state == OFF);
        if (boundary && bus.load) begin
            applied_nxt = bus.bcd_in;
            pending_nxt = bus.bcd_in;
            upd_nxt     = 1'b0;
        end else begin
            if (apply_now && upd) begin
                applied_nxt = pending;
                upd_nxt     = 1'b0;
            end
            if (bus.load) begin
                pending_nxt = bus.bcd_in;
                upd_nxt     = 1'b1;
            end
        end

        err_nxt   = has_bad_digit(applied_nxt);
        cur_digit = applied_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank     = lz_blank(applied_nxt, idx_nxt);
`else
        blank     = 1'b0;
`endif
        if (state_nxt == SHOW) begin
            dig_nxt = 4'(4'b0001 << idx_nxt);
            seg_nxt = blank ? 7'b0000000 : seg_code(cur_digit);
        end else begin
            dig_nxt = 4'b0000;
            seg_nxt = 7'b0000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            idx     <= 2'd0;
            cnt     <= 16'd0;
            applied <= 16'd0;
            pending <= 16'd0;
            upd     <= 1'b0;
            seg_q   <= 7'b0000000;
            dig_q   <= 4'b0000;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            applied <= applied_nxt;
            pending <= pending_nxt;
            upd     <= upd_nxt;
            seg_q   <= seg_nxt;
            dig_q   <= dig_nxt;
            fd_q    <= boundary;
            err_q   <= err_nxt;
        end
    end

    assign bus.svnsg      = seg_q;
    assign bus.dig        = dig_q;
    assign bus.upd_pend   = upd;
    assign bus.frame_done = fd_q;
    assign bus.err        = err_q;
endmodule
